// File: rtl/axi_rd_pkg.sv
// Shared constants and state type for the AXI4 read-channel responder.
package axi_rd_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_e;

endpackage

// File: rtl/axi_rd_mem.sv
// Local word memory: synchronous backdoor write, combinational read.
// Ports:
//   clk         rising-edge clock
//   we/waddr/wdata  backdoor write port
//   raddr       combinational read index
//   rdata_c     read data (unregistered; the parent registers it)
module axi_rd_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata_c
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read sees pre-edge contents, so a same-edge write loads old data.
    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/axi_read_slave.sv
// AXI4 read-channel responder: accepts one AR request at a time and streams
// ARLEN+1 beats from local memory with per-beat OKAY/SLVERR.
// Ports:
//   clkk, resett          clock and synchronous active-high reset
//   base_addr/limit_addr  inclusive decoded byte range
//   AR*                   read-address channel (slave side)
//   R*                    read-data channel (slave side)
//   mem_we/waddr/wdata    backdoor memory preload port
module axi_read_slave
    import axi_rd_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                         clkk,
    input  logic                         resett,
    input  logic [31:0]                  base_addr,
    input  logic [31:0]                  limit_addr,
    input  logic [ID_W-1:0]              ARID,
    input  logic [ADDR_W-1:0]            ARADDR,
    input  logic [7:0]                   ARLEN,
    input  logic [2:0]                   ARSIZE,
    input  logic [1:0]                   ARBURST,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [ID_W-1:0]              RID,
    output logic [DATA_W-1:0]            RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_W-1:0]            mem_wdata
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    state_e             st_q, st_d;
    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic [ID_W-1:0]    rid_q, rid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;
    logic               rlast_q, rlast_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         beat_q, beat_d;
    logic [1:0]         burst_q, burst_d;
    logic               err_q, err_d;

    logic               ar_err_c;
    logic [ADDR_W-1:0]  nxt_addr_c;
    logic [ADDR_W-1:0]  ld_addr_c;
    logic               ld_err_c;
    logic [7:0]         ld_len_c;
    logic [7:0]         ld_beat_c;
    logic               ld_bad_c;
    logic               ld_en_c;
    logic [DATA_W-1:0]  mem_rdata_c;

    axi_rd_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk     (clkk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr   (ld_addr_c[2 +: IDX_W]),
        .rdata_c (mem_rdata_c)
    );

    // Beat-load operands: in IDLE they come straight from the AR channel
    // (beat 0); in BURST they describe the next beat of the captured request.
    always_comb begin
        ar_err_c   = (ARSIZE != SIZE_4B) ||
                     ((ARBURST != BURST_FIXED) && (ARBURST != BURST_INCR));
        nxt_addr_c = (burst_q == BURST_FIXED) ? addr_q : addr_q + ADDR_W'(4);
        ld_addr_c  = nxt_addr_c;
        ld_err_c   = err_q;
        ld_len_c   = len_q;
        ld_beat_c  = beat_q + 8'd1;
        if (st_q == ST_IDLE) begin
            ld_addr_c = ARADDR;
            ld_err_c  = ar_err_c;
            ld_len_c  = ARLEN;
            ld_beat_c = 8'd0;
        end
        ld_bad_c = ld_err_c ||
                   (32'(ld_addr_c) < base_addr) ||
                   (32'(ld_addr_c) > limit_addr);
    end

    // Next-state and registered-output logic.
    always_comb begin
        st_d      = st_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        err_d     = err_q;
        ld_en_c   = 1'b0;

        case (st_q)
            ST_IDLE: begin
                if (ARVALID && arready_q) begin
                    rid_d     = ARID;
                    addr_d    = ld_addr_c;
                    len_d     = ARLEN;
                    burst_d   = ARBURST;
                    err_d     = ar_err_c;
                    beat_d    = ld_beat_c;
                    ld_en_c   = 1'b1;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    st_d      = ST_BURST;
                end
            end
            ST_BURST: begin
                if (rvalid_q && RREADY) begin
                    if (rlast_q) begin
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        st_d      = ST_IDLE;
                    end else begin
                        addr_d  = ld_addr_c;
                        beat_d  = ld_beat_c;
                        ld_en_c = 1'b1;
                    end
                end
            end
            default: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                st_d      = ST_IDLE;
            end
        endcase

        // Out-of-range or malformed requests return zero data with SLVERR.
        if (ld_en_c) begin
            rdata_d = ld_bad_c ? '0 : mem_rdata_c;
            rresp_d = ld_bad_c ? RESP_SLVERR : RESP_OKAY;
            rlast_d = (ld_beat_c == ld_len_c);
        end
    end

    always_ff @(posedge clkk) begin
        if (resett) begin
            st_q      <= ST_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            burst_q   <= BURST_FIXED;
            err_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

endmodule

// File: doc/axi_read_slave.md
# axi_read_slave

AXI4 read-channel responder that stands behind the read interconnect as one of its two slave ports. It accepts a read-address request, then streams an ARLEN+1-beat read-data burst from a local word memory with per-beat RRESP. One transaction is outstanding at a time. The local memory is preloaded through a synchronous backdoor write port.

## Interface
Parameters:
- DATA_W, 32: RDATA width; fixed at 32 (4-byte beats).
- ADDR_W, 32: ARADDR width.
- ID_W, 4: ARID/RID width.
- MEM_DEPTH, 256: number of 32-bit words in local memory; power of two.

Ports:
- clkk  in  1  clock; all logic is on the rising edge.
- resett  in  1  **synchronous, active-high reset.**
- base_addr  in  32  lowest byte address decoded by this slave (register file).
- limit_addr  in  32  highest byte address decoded by this slave (inclusive).
- ARID  in  ID_W  request ID.
- ARADDR  in  ADDR_W  start byte address.
- ARLEN  in  8  beats minus 1.
- ARSIZE  in  3  beat size; only 3'b010 is legal.
- ARBURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address ready.
- RID  out  ID_W  response ID (captured ARID).
- RDATA  out  DATA_W  read data.
- RRESP  out  2  per-beat response: 00 OKAY, 10 SLVERR.
- RLAST  out  1  final beat of the burst.
- RVALID  out  1  data valid.
- RREADY  in  1  master ready.
- mem_we  in  1  backdoor write enable.
- mem_waddr  in  $clog2(MEM_DEPTH)  backdoor word index.
- mem_wdata  in  DATA_W  backdoor data.

## Operation
- States: IDLE and BURST.
- IDLE:
  - ARREADY=1, RVALID=0.
  - On ARVALID&&ARREADY: capture ARID, ARADDR, ARLEN, ARBURST. Set the request-error flag when ARSIZE!=3'b010 or ARBURST is 10 or 11.
  - Load beat 0 into the R registers and go to BURST.
- BURST:
  - ARREADY=0, RVALID=1.
  - On RVALID&&RREADY when the beat is not last: advance the address, increment the beat counter, and load the next beat into the R registers.
  - On the handshake with RLAST=1: go to IDLE.
- Beat load rules:
  - RDATA=mem[addr[2+$clog2(MEM_DEPTH)-1:2]]; address bits [1:0] are ignored.
  - RRESP=SLVERR and RDATA=0 when the request-error flag is set, or when the beat address is < base_addr or > limit_addr. Otherwise RRESP=OKAY.
  - RLAST=1 exactly when beat count == captured ARLEN.
- Address advance:
  - INCR adds 4 (mod 2^ADDR_W).
  - FIXED holds the address.
  - The memory index wraps modulo MEM_DEPTH. The range check uses the full 32-bit address.
- An erroneous request still returns the full ARLEN+1 beats.
- Backdoor write: mem[mem_waddr]<=mem_wdata on the clkk edge when mem_we=1. The write is independent of bus state. A beat already loaded into RDATA is not altered by a later write.

## Timing
- Reset values: state=IDLE, ARREADY=1 in the cycle after reset, RVALID=0, RLAST=0, RRESP=00, RDATA=0, RID=0. Memory contents are not reset.
- Resetting mid-burst abandons the burst: RVALID=0 on the next cycle and no further beats are produced.
- Latency:
  - AR handshake at edge N gives RVALID=1 with beat 0 after edge N.
  - After a non-last handshake, the next beat is presented in the following cycle, so throughput is 1 beat/cycle with RREADY held high.
- Stall rule: while RVALID=1 and RREADY=0, RID, RDATA, RRESP and RLAST hold stable.
- Turnaround: after the last handshake at edge M, ARREADY=1 after edge M. A back-to-back request costs 1 idle R cycle.
- ARREADY and RVALID are never both 1. ARVALID is ignored in BURST.
- Read-during-write: a backdoor write and a beat load to the same word on the same edge load the old data.

## Structure
- Package axi_rd_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - BURST_FIXED=2'b00, BURST_INCR=2'b01.
  - SIZE_4B=3'b010.
  - The state enum {ST_IDLE, ST_BURST}.
- Sub-module axi_rd_mem: MEM_DEPTH×DATA_W array with synchronous write and combinational read. The parent registers the read output into RDATA.

## Test plan
- Single beat: preload mem[4]=32'hDEADBEEF; base=0, limit=32'h3FF; AR addr=0x10, len=0, INCR, id=3 → one beat with RDATA=DEADBEEF, RID=3, RRESP=OKAY, RLAST=1, RVALID one cycle after the AR handshake.
- INCR burst with stalls: mem[i]=i; addr=0x0, len=3; RREADY toggles 1,0,0,1,1,1 → data 0,1,2,3 in order, RLAST only on data 3, outputs stable on stalled cycles.
- Wrap and FIXED bursts:
  - Memory-index wrap: MEM_DEPTH=256, limit=32'hFFFFFFFF, addr=0x3F8, len=3, INCR → indices 254, 255, 0, 1, all OKAY.
  - FIXED: addr=0x20, len=2 → mem[8] returned three times.
- Range and request errors:
  - base=0x100, limit=0x10F, addr=0x108, len=3, INCR → OKAY, OKAY, SLVERR(data 0), SLVERR.
  - ARSIZE=3'b001 → 4 beats of SLVERR with RLAST on beat 4.
- Back-to-back and reset:
  - ARVALID held with two requests → ARREADY low throughout burst 1; second AR accepted the cycle after burst 1's RLAST handshake.
  - resett pulsed mid-burst → RVALID=0 next cycle, ARREADY=1 the cycle after reset deasserts.
